// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: branch redirect/flush, RAW-hazard stalls, halt/drain/resume.
// Define PIPE_CTRL_FORWARD_EN to enable operand forwarding with load-use-only stalls.
module pipe_ctrl #(
    parameter int ARQ   = 16,
    parameter int RADDR = 4,
    parameter int PCW   = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RADDR-1:0] ex_rd,
    input  logic             ex_wr,
    input  logic             ex_is_load,
    input  logic [RADDR-1:0] mem_rd,
    input  logic             mem_wr,
    input  logic             branch_taken,
    input  logic [PCW-1:0]   jaddr,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             pc_load,
    output logic [PCW-1:0]   pc_target,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [ARQ-1:0]   stall_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t     state;
    logic [1:0] dcnt;
    logic       ex_match, mem_match, hz, stall;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    assign ex_match  = (id_use_rs1 && id_rs1 == ex_rd)  || (id_use_rs2 && id_rs2 == ex_rd);
    assign mem_match = (id_use_rs1 && id_rs1 == mem_rd) || (id_use_rs2 && id_rs2 == mem_rd);

`ifdef PIPE_CTRL_FORWARD_EN
    assign hz = ex_wr && ex_is_load && ex_match;

    // EX producer is younger than MEM, so its value wins
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (id_use_rs1) begin
            if (ex_wr && ex_rd == id_rs1)
                fwd_a_sel = 2'b01;
            else if (mem_wr && mem_rd == id_rs1)
                fwd_a_sel = 2'b10;
        end
        if (id_use_rs2) begin
            if (ex_wr && ex_rd == id_rs2)
                fwd_b_sel = 2'b01;
            else if (mem_wr && mem_rd == id_rs2)
                fwd_b_sel = 2'b10;
        end
    end
`else
    logic unused_load;
    assign unused_load = ex_is_load;
    assign hz          = (ex_wr && ex_match) || (mem_wr && mem_match);
    assign fwd_a_sel   = 2'b00;
    assign fwd_b_sel   = 2'b00;
`endif

    assign stall = (state == RUN) && !branch_taken && !halt_req && hz;

    always_comb begin
        pc_en       = 1'b0;
        pc_load     = 1'b0;
        pc_target   = '0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (!rst) begin
            fwd_a       = fwd_a_sel;
            fwd_b       = fwd_b_sel;
            if_id_flush = 1'b0;
            if (branch_taken) begin
                pc_load     = 1'b1;
                pc_target   = jaddr;
                if_id_flush = 1'b1;
            end else if (state == RUN && !halt_req && !hz) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_flush = 1'b0;
            end
        end
    end

    // Drain lets the three older instructions leave EX/MEM/WB before reporting halted
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            dcnt      <= 2'd0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state <= DRAIN;
                        dcnt  <= 2'd0;
                    end
                    if (stall && stall_cnt != '1)
                        stall_cnt <= stall_cnt + 1'b1;
                end
                DRAIN: begin
                    dcnt <= dcnt + 2'd1;
                    if (dcnt == 2'd2) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl; covers reset, branch, hazard/forwarding, halt and saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic        id_use_rs1, id_use_rs2, ex_wr, ex_is_load, mem_wr;
    logic        branch_taken, halt_req, resume;
    logic [12:0] jaddr;
    logic        pc_en, pc_load, if_id_en, if_id_flush, id_ex_flush, halted;
    logic [12:0] pc_target;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_cnt;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .branch_taken(branch_taken), .jaddr(jaddr),
        .halt_req(halt_req), .resume(resume),
        .pc_en(pc_en), .pc_load(pc_load), .pc_target(pc_target),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 4'd1; id_rs2 = 4'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 4'd9; ex_wr = 1'b0; ex_is_load = 1'b0;
        mem_rd = 4'd10; mem_wr = 1'b0;
        branch_taken = 1'b0; jaddr = 13'd0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        total++; if (if_id_flush !== 1'b1) begin bad++; $display("[TB] FAIL reset_if_id_flush got=%b want=1", if_id_flush); end
        total++; if (id_ex_flush !== 1'b1) begin bad++; $display("[TB] FAIL reset_id_ex_flush got=%b want=1", id_ex_flush); end
        total++; if (pc_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_pc_en got=%b want=0", pc_en); end
        total++; if (pc_target !== 13'd0) begin bad++; $display("[TB] FAIL reset_pc_target got=%0d want=0", pc_target); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%b want=0", halted); end
        rst = 1'b0;
        #1;
        total++; if (pc_en !== 1'b1) begin bad++; $display("[TB] FAIL release_pc_en got=%b want=1", pc_en); end
        total++; if (if_id_flush !== 1'b0) begin bad++; $display("[TB] FAIL release_if_id_flush got=%b want=0", if_id_flush); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_branch();
        tick();
        id_rs1 = 4'd3; id_use_rs1 = 1'b1;
        ex_rd = 4'd3; ex_wr = 1'b1; ex_is_load = 1'b1;
        branch_taken = 1'b1; jaddr = 13'd1500;
        #1;
        total++; if (pc_load !== 1'b1) begin bad++; $display("[TB] FAIL branch_pc_load got=%b want=1", pc_load); end
        total++; if (pc_target !== 13'd1500) begin bad++; $display("[TB] FAIL branch_pc_target got=%0d want=1500", pc_target); end
        total++; if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin bad++; $display("[TB] FAIL branch_flush got=%b%b want=11", if_id_flush, id_ex_flush); end
        tick();
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL branch_stall_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
        idle_inputs();
        #1;
        total++; if (pc_load !== 1'b0 || pc_target !== 13'd0) begin bad++; $display("[TB] FAIL nobranch_pc_load got=%b/%0d want=0/0", pc_load, pc_target); end
    endtask

`ifdef PIPE_CTRL_FORWARD_EN
    task automatic test_forward();
        id_rs1 = 4'd3; id_use_rs1 = 1'b1;
        ex_rd = 4'd3; ex_wr = 1'b1; mem_rd = 4'd3; mem_wr = 1'b1;
        #1;
        total++; if (fwd_a !== 2'b01) begin bad++; $display("[TB] FAIL fwd_ex_prio got=%b want=01", fwd_a); end
        total++; if (pc_en !== 1'b1) begin bad++; $display("[TB] FAIL fwd_no_stall got=%b want=1", pc_en); end
        ex_wr = 1'b0;
        #1;
        total++; if (fwd_a !== 2'b10) begin bad++; $display("[TB] FAIL fwd_mem got=%b want=10", fwd_a); end
        id_use_rs1 = 1'b0;
        #1;
        total++; if (fwd_a !== 2'b00) begin bad++; $display("[TB] FAIL fwd_unused got=%b want=00", fwd_a); end
        id_use_rs1 = 1'b1; ex_wr = 1'b1; ex_is_load = 1'b1;
        #1;
        total++; if (pc_en !== 1'b0 || id_ex_flush !== 1'b1) begin bad++; $display("[TB] FAIL load_use_stall got=%b%b want=01", pc_en, id_ex_flush); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL load_use_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
        idle_inputs();
        #1;
    endtask
`else
    task automatic test_stall();
        id_rs2 = 4'd5; id_use_rs2 = 1'b1;
        mem_rd = 4'd5; mem_wr = 1'b1;
        #1;
        total++; if (pc_en !== 1'b0 || if_id_en !== 1'b0) begin bad++; $display("[TB] FAIL mem_hz_stall got=%b%b want=00", pc_en, if_id_en); end
        total++; if (id_ex_flush !== 1'b1) begin bad++; $display("[TB] FAIL mem_hz_flush got=%b want=1", id_ex_flush); end
        total++; if (fwd_b !== 2'b00) begin bad++; $display("[TB] FAIL nofwd_b got=%b want=00", fwd_b); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL mem_hz_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
        mem_wr = 1'b0;
        #1;
        total++; if (pc_en !== 1'b1) begin bad++; $display("[TB] FAIL producer_gone got=%b want=1", pc_en); end
        id_rs1 = 4'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0; ex_rd = 4'd0; ex_wr = 1'b1;
        #1;
        total++; if (pc_en !== 1'b0) begin bad++; $display("[TB] FAIL r0_hz got=%b want=0", pc_en); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        idle_inputs();
        #1;
    endtask
`endif

    task automatic test_halt();
        halt_req = 1'b1;
        #1;
        total++; if (pc_en !== 1'b0 || id_ex_flush !== 1'b1) begin bad++; $display("[TB] FAIL halt_req_cycle got=%b%b want=01", pc_en, id_ex_flush); end
        tick();
        halt_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            resume = (i == 2);
            #1;
            total++; if (halted !== 1'b0 || id_ex_flush !== 1'b1 || pc_en !== 1'b0)
                begin bad++; $display("[TB] FAIL drain_cycle%0d got halted=%b flush=%b pc_en=%b want 0/1/0", i, halted, id_ex_flush, pc_en); end
            tick();
        end
        resume = 1'b0;
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halted_t4 got=%b want=1", halted); end
        total++; if (id_ex_flush !== 1'b1 || pc_en !== 1'b0) begin bad++; $display("[TB] FAIL halted_outputs got=%b%b want=10", id_ex_flush, pc_en); end
        branch_taken = 1'b1; jaddr = 13'd77;
        #1;
        total++; if (pc_load !== 1'b1 || if_id_flush !== 1'b1) begin bad++; $display("[TB] FAIL halted_branch got=%b%b want=11", pc_load, if_id_flush); end
        tick();
        branch_taken = 1'b0;
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halted_after_branch got=%b want=1", halted); end
        resume = 1'b1;
        #1;
        total++; if (pc_en !== 1'b0) begin bad++; $display("[TB] FAIL resume_cycle got=%b want=0", pc_en); end
        tick();
        resume = 1'b0;
        #1;
        total++; if (pc_en !== 1'b1 || halted !== 1'b0) begin bad++; $display("[TB] FAIL resumed got=%b%b want=10", pc_en, halted); end
    endtask

    task automatic test_saturation();
        id_rs1 = 4'd7; id_use_rs1 = 1'b1;
        ex_rd = 4'd7; ex_wr = 1'b1; ex_is_load = 1'b1;
        for (int i = 0; i < 65535 - int'(exp_cnt) - 1; i++) tick();
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("[TB] FAIL sat_pre got=%h want=fffe", stall_cnt); end
        tick();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_reach got=%h want=ffff", stall_cnt); end
        tick();
        tick();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_hold got=%h want=ffff", stall_cnt); end
        idle_inputs();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total++; if (pc_en !== 1'b0 || if_id_flush !== 1'b1) begin bad++; $display("[TB] FAIL drain_rst_outputs got=%b%b want=01", pc_en, if_id_flush); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (pc_en !== 1'b1 || halted !== 1'b0) begin bad++; $display("[TB] FAIL drain_rst_run got=%b%b want=10", pc_en, halted); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL drain_rst_cnt got=%h want=0", stall_cnt); end
        tick();
        tick();
        #1;
        total++; if (halted !== 1'b0 || pc_en !== 1'b1) begin bad++; $display("[TB] FAIL drain_rst_stays got=%b%b want=01", halted, pc_en); end
    endtask

    initial begin
        test_reset();
        test_branch();
`ifdef PIPE_CTRL_FORWARD_EN
        test_forward();
`else
        test_stall();
`endif
        test_halt();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
